// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU op encodings and flag bit positions
package alu_arbiter_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 32-bit add/sub/and/or ALU with NZCV flags
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  alu_op_e           op,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        flags
);

   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] b_eff;
   logic              arith;

   // Subtract is a + ~b + 1, so carry-out high means no borrow.
   always_comb begin
      arith = (op == ALU_ADD) || (op == ALU_SUB);
      b_eff = (op == ALU_SUB) ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, (op == ALU_SUB)};
      case (op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         default: result = sum[DATA_W-1:0];
      endcase
      flags         = '0;
      flags[FLAG_N] = result[DATA_W-1];
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_C] = arith & sum[DATA_W];
      flags[FLAG_V] = arith & (a[DATA_W-1] == b_eff[DATA_W-1]) & (result[DATA_W-1] != a[DATA_W-1]);
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port valid/ready arbiter sharing one ALU behind a registered response
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [1:0]        req0_ctrl,
   input  logic [TAG_W-1:0]  req0_tag,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [1:0]        req1_ctrl,
   input  logic [TAG_W-1:0]  req1_tag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic [3:0]        rsp_flags,
   output logic              rsp_id,
   output logic [TAG_W-1:0]  rsp_tag
);

   logic              last_grant;
   logic              grant;
   logic              can_accept;
   logic              accept;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   alu_op_e           alu_op;
   logic [TAG_W-1:0]  sel_tag;
   logic [DATA_W-1:0] alu_result;
   logic [3:0]        alu_flags;

   // grant names the winning port; it is only meaningful when some valid is high.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid)
         grant = RR_EN ? ~last_grant : 1'b0;
      else if (req1_valid)
         grant = 1'b1;
      can_accept = ~rsp_valid | rsp_ready;
      req0_ready = can_accept & req0_valid & ~grant;
      req1_ready = can_accept & req1_valid & grant;
      accept     = req0_ready | req1_ready;
   end

   always_comb begin
      alu_a   = grant ? req1_a : req0_a;
      alu_b   = grant ? req1_b : req0_b;
      alu_op  = alu_op_e'(grant ? req1_ctrl : req0_ctrl);
      sel_tag = grant ? req1_tag : req0_tag;
   end

   alu_arbiter_alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .op     (alu_op),
      .result (alu_result),
      .flags  (alu_flags)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_id     <= 1'b0;
         rsp_tag    <= '0;
         last_grant <= 1'b1;
      end else if (accept) begin
         rsp_valid  <= 1'b1;
         rsp_result <= alu_result;
         rsp_flags  <= alu_flags;
         rsp_id     <= grant;
         rsp_tag    <= sel_tag;
         if (RR_EN)
            last_grant <= grant;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench: directed vectors plus modelled mixed traffic
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int TW = 4;

   typedef struct packed {
      logic [31:0]   result;
      logic [3:0]    flags;
      logic          id;
      logic [TW-1:0] tag;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req1_valid, rsp_ready;
   logic [31:0]   req0_a, req0_b, req1_a, req1_b;
   logic [1:0]    req0_ctrl, req1_ctrl;
   logic [TW-1:0] req0_tag, req1_tag;
   logic          req0_ready, req1_ready, rsp_valid, rsp_id;
   logic [31:0]   rsp_result;
   logic [3:0]    rsp_flags;
   logic [TW-1:0] rsp_tag;
   logic          fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
   logic [31:0]   fp_rsp_result;
   logic [3:0]    fp_rsp_flags;
   logic [TW-1:0] fp_rsp_tag;

   always #5 clk = ~clk;

   alu_arbiter #(.RR_EN(1'b1), .TAG_W(TW)) u_rr (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ctrl(req0_ctrl), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ctrl(req1_ctrl), .req1_tag(req1_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_id(rsp_id), .rsp_tag(rsp_tag)
   );

   alu_arbiter #(.RR_EN(1'b0), .TAG_W(TW)) u_fp (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ctrl(req0_ctrl), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ctrl(req1_ctrl), .req1_tag(req1_tag),
      .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(fp_rsp_result),
      .rsp_flags(fp_rsp_flags), .rsp_id(fp_rsp_id), .rsp_tag(fp_rsp_tag)
   );

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
   endtask

   task automatic push(input logic [31:0] r, input logic [3:0] f, input logic id, input logic [TW-1:0] tag);
      exp_q.push_back('{result: r, flags: f, id: id, tag: tag});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input alu_op_e op, input logic [TW-1:0] tag);
      req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = op; req0_tag = tag;
   endtask

   task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input alu_op_e op, input logic [TW-1:0] tag);
      req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = op; req1_tag = tag;
   endtask

   // Reference ALU written from the arithmetic definitions, not the adder form.
   function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                                   input logic id, input logic [TW-1:0] tag);
      exp_t   e;
      longint sr;
      logic   c, v;
      logic [31:0] r;
      c = 1'b0; v = 1'b0; sr = 0;
      case (op)
         2'b00: begin
            r  = a + b;
            c  = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
            sr = longint'($signed(a)) + longint'($signed(b));
         end
         2'b01: begin
            r  = a - b;
            c  = (a >= b);
            sr = longint'($signed(a)) - longint'($signed(b));
         end
         2'b10: r = a & b;
         default: r = a | b;
      endcase
      if (op[1] == 1'b0) v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      e.result = r;
      e.flags  = {r[31], (r == 32'd0), c, v};
      e.id     = id;
      e.tag    = tag;
      return e;
   endfunction

   exp_t e_pop, snap;
   logic held = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         held = 1'b0;
      end else begin
         if (held && rsp_valid) begin
            check("hold_result", rsp_result, snap.result);
            check("hold_flags", rsp_flags, snap.flags);
            check("hold_id", rsp_id, snap.id);
            check("hold_tag", rsp_tag, snap.tag);
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_rsp: got id %0d tag %0d result 0x%0h, expected no response",
                        rsp_id, rsp_tag, rsp_result);
            end else begin
               e_pop = exp_q.pop_front();
               check("rsp_result", rsp_result, e_pop.result);
               check("rsp_flags", rsp_flags, e_pop.flags);
               check("rsp_id", rsp_id, e_pop.id);
               check("rsp_tag", rsp_tag, e_pop.tag);
            end
         end
         held = rsp_valid && !rsp_ready;
         snap = '{result: rsp_result, flags: rsp_flags, id: rsp_id, tag: rsp_tag};
      end
   end

   logic          pv[2];
   logic [31:0]   pa[2], pb[2];
   logic [1:0]    pop_c[2];
   logic [TW-1:0] ptag[2];
   logic          m_rv, m_last;
   int            win;

   initial begin
      reset = 1'b0; rsp_ready = 1'b0;
      drive0(0, 0, 0, ALU_ADD, 0);
      drive1(0, 0, 0, ALU_ADD, 0);
      #12;
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_result", rsp_result, 0);
      check("reset_rsp_flags", rsp_flags, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_rsp_tag", rsp_tag, 0);
      tick(); reset = 1'b1;

      // Port 0 add overflowing into the sign bit.
      rsp_ready = 1'b1;
      drive0(1, 32'h7FFF_FFFF, 32'h1, ALU_ADD, 3);
      push(32'h8000_0000, 4'b1001, 0, 3);
      @(negedge clk);
      check("t1_req0_ready", req0_ready, 1);
      check("t1_req1_ready", req1_ready, 0);
      tick(); req0_valid = 1'b0;
      @(negedge clk);
      check("t1_rsp_valid", rsp_valid, 1);

      // Port 1 sub to zero, then drain with no new request.
      tick();
      drive1(1, 32'd5, 32'd5, ALU_SUB, 9);
      push(32'd0, 4'b0110, 1, 9);
      @(negedge clk);
      check("t2_req1_ready", req1_ready, 1);
      check("t2_req0_ready", req0_ready, 0);
      tick(); req1_valid = 1'b0;
      tick();
      @(negedge clk);
      check("t2_drain_valid", rsp_valid, 0);
      check("t2_drain_tag_held", rsp_tag, 9);

      // Continuous tie: round-robin alternates, fixed priority always port 0.
      tick(); reset = 1'b0;
      tick(); reset = 1'b1;
      drive0(1, 32'h0000_F0F0, 32'h0000_0FF0, ALU_AND, 1);
      drive1(1, 32'h1, 32'h2, ALU_OR, 2);
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) push(32'h0000_00F0, 4'b0000, 0, 1);
         else            push(32'h0000_0003, 4'b0000, 1, 2);
         @(negedge clk);
         check("t3_rr_req0_ready", req0_ready, (k % 2) == 0);
         check("t3_rr_req1_ready", req1_ready, (k % 2) == 1);
         check("t3_fp_req0_ready", fp_req0_ready, 1);
         check("t3_fp_req1_ready", fp_req1_ready, 0);
         if (k > 0) check("t3_fp_rsp_id", fp_rsp_id, 0);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      // Backpressure with both ports waiting; port 1 is the pending winner.
      drive0(1, 32'd10, 32'd20, ALU_ADD, 4);
      drive1(1, 32'd3, 32'd5, ALU_SUB, 5);
      push(32'd30, 4'b0000, 0, 4);
      push(32'hFFFF_FFFE, 4'b1000, 1, 5);
      push(32'd2, 4'b0000, 0, 6);
      @(negedge clk);
      check("t4_first_req0_ready", req0_ready, 1);
      tick();
      rsp_ready = 1'b0;
      drive0(1, 32'd1, 32'd1, ALU_ADD, 6);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_stall_req0_ready", req0_ready, 0);
         check("t4_stall_req1_ready", req1_ready, 0);
         check("t4_stall_rsp_valid", rsp_valid, 1);
         check("t4_stall_result", rsp_result, 30);
         check("t4_stall_tag", rsp_tag, 4);
         tick();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t4_release_req1_ready", req1_ready, 1);
      check("t4_release_req0_ready", req0_ready, 0);
      tick(); req1_valid = 1'b0;
      @(negedge clk);
      check("t4_after_req0_ready", req0_ready, 1);
      tick(); req0_valid = 1'b0;
      tick(); tick();

      // Asynchronous reset while a response is held and a request waits.
      rsp_ready = 1'b0;
      drive0(1, 32'd100, 32'd1, ALU_ADD, 7);
      @(negedge clk);
      check("t5_req0_ready", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      drive1(1, 32'd8, 32'd8, ALU_AND, 8);
      @(negedge clk);
      check("t5_rsp_valid_before", rsp_valid, 1);
      check("t5_req1_ready_stalled", req1_ready, 0);
      #2 reset = 1'b0;
      #1;
      check("t5_async_rsp_valid", rsp_valid, 0);
      check("t5_async_rsp_tag", rsp_tag, 0);
      req1_valid = 1'b0;
      tick(); tick(); reset = 1'b1;
      rsp_ready = 1'b1;
      drive0(1, 32'hFFFF_FFFF, 32'h1, ALU_ADD, 10);
      drive1(1, 32'h8000_0000, 32'h1, ALU_SUB, 11);
      push(32'h0, 4'b0110, 0, 10);
      push(32'h7FFF_FFFF, 4'b0011, 1, 11);
      @(negedge clk);
      check("t5_tie_req0_ready", req0_ready, 1);
      check("t5_tie_req1_ready", req1_ready, 0);
      tick(); req0_valid = 1'b0;
      @(negedge clk);
      check("t5_next_req1_ready", req1_ready, 1);
      tick(); req1_valid = 1'b0;
      tick(); tick();

      // Mixed traffic against the bench's own grant and response model.
      m_rv = 1'b0; m_last = 1'b1;
      pv[0] = 1'b0; pv[1] = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pv[p] && $urandom_range(0, 2) != 0) begin
               pv[p]    = 1'b1;
               pa[p]    = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
               pb[p]    = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom;
               pop_c[p] = 2'($urandom_range(0, 3));
               ptag[p]  = TW'($urandom);
            end
         end
         req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_ctrl = pop_c[0]; req0_tag = ptag[0];
         req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_ctrl = pop_c[1]; req1_tag = ptag[1];
         rsp_ready = ($urandom_range(0, 3) != 0);
         win = -1;
         if (!m_rv || rsp_ready) begin
            if (pv[0] && pv[1]) win = m_last ? 0 : 1;
            else if (pv[0])     win = 0;
            else if (pv[1])     win = 1;
         end
         @(negedge clk);
         check("rnd_req0_ready", req0_ready, win == 0);
         check("rnd_req1_ready", req1_ready, win == 1);
         check("rnd_rsp_valid", rsp_valid, m_rv);
         @(posedge clk);
         if (win >= 0) begin
            exp_q.push_back(ref_op(pa[win], pb[win], pop_c[win], win[0], ptag[win]));
            pv[win] = 1'b0;
            m_last  = win[0];
            m_rv    = 1'b1;
         end else if (rsp_ready) begin
            m_rv = 1'b0;
         end
         #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      tick(); tick(); tick();
      check("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit integer ALU (2-bit op: add/sub/and/or; NZCV flags) between two requesters.
  - Port 0: execute-stage operand path.
  - Port 1: multicycle helper path, e.g. address generation.
- Uses valid/ready handshakes on both request ports and on one common response port.
- Arbitration is round-robin, or fixed priority when configured.
- The result and flags are registered, so there is 1 cycle of latency from accept to response. The response register stalls while the consumer backpressures.

Parameters:
- RR_EN, 1: 1 = round-robin on ties; 0 = fixed priority, port 0 always wins.
- TAG_W, 4: width of the requester-supplied tag returned with each result.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; clears all state while low.
- req0_valid  input  1  port 0 presents an operation.
- req0_ready  output  1  port 0 operation accepted this cycle when high with req0_valid.
- req0_a  input  32  port 0 operand A.
- req0_b  input  32  port 0 operand B.
- req0_ctrl  input  2  port 0 op: 00 add, 01 sub, 10 and, 11 or.
- req0_tag  input  TAG_W  port 0 tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl, req1_tag: same as port 0, for port 1.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_result  output  32  registered ALU result.
- rsp_flags  output  4  registered {N,Z,C,V}.
- rsp_id  output  1  requester that owns the response (0/1).
- rsp_tag  output  TAG_W  tag of the owning request.

Behaviour:
- Reset (reset low, asynchronous):
  - rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_id=0, rsp_tag=0.
  - last_grant=1, so port 0 wins the first tie.
  - Any in-flight response is dropped and not replayed.
- can_accept = ~rsp_valid | rsp_ready. A new op may enter in the same cycle the old response leaves, giving full throughput of 1 op/cycle.
- Grant is combinational from req*_valid, last_grant and RR_EN:
  - Only one valid: that port wins.
  - Both valid, RR_EN=1: the port != last_grant wins.
  - Both valid, RR_EN=0: port 0 wins.
- reqN_ready = can_accept & grantN. Ready may depend on valid. Ready never goes high for a port whose valid is low. At most one ready is high per cycle.
- Handshake rules:
  - Requesters hold a, b, ctrl and tag stable while valid is high and ready is low.
  - Valid must not drop before acceptance.
- On accept (reqN_valid & reqN_ready), at the next rising edge:
  - The response register loads the ALU result, flags, id=N and tagN; rsp_valid=1.
  - last_grant=N (RR_EN=1 only).
- Mux and ALU path:
  - The ALU is fed from a mux selected by the grant. The ALU is purely combinational.
  - Only the grant selects the mux, so operands of an unaccepted port never reach the register.
- Flags follow the ALU rules:
  - N = result[31]; Z = result==0.
  - C = carry-out of add/sub, 0 for and/or. C=1 on sub means no borrow.
  - V = signed overflow for add/sub, 0 for and/or.
- Response side:
  - rsp_valid & ~rsp_ready with no accept: the response register holds all fields stable and both readies are 0.
  - rsp_ready & ~accept: rsp_valid falls to 0 on the next edge. Other rsp fields hold their last value.
- last_grant is not updated when no accept occurs, so a stalled tie keeps its pending winner.
- Starvation bound (RR_EN=1): a continuously valid port waits at most 1 accepted op by the other port.
- Simultaneous events (rsp_ready, a new accept and both valids in one cycle) are covered by the rules above; no extra cycle is inserted.

Decomposition:
- Shared package: ALU op encodings (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11) and flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One sub-module: the existing alu, instantiated once behind the grant mux.
- Grant logic, response register and last_grant live in alu_arbiter itself.

Test Plan:
- Port 0 only: add 0x7FFFFFFF + 0x00000001, tag 3 → next cycle rsp_valid=1, result 0x80000000, flags 1001, id 0, tag 3.
- Port 1 only: sub 5 - 5, tag 9 → result 0, flags 0110, id 1, tag 9. With rsp_ready=1 and no new request, rsp_valid=0 the following cycle.
- After reset, both ports continuously valid (p0 and 0xF0F0 & 0x0FF0; p1 or 0x1 | 0x2) with rsp_ready=1 → responses alternate id 0,1,0,1 with results 0x00F0, 0x3, ... at 1 result/cycle. With RR_EN=0, every response is id 0.
- Backpressure: hold rsp_ready=0 for 3 cycles with both ports valid → rsp fields frozen, req0_ready=req1_ready=0. When rsp_ready rises, the pending winner is accepted that same cycle.
- Reset mid-operation: assert reset while rsp_valid=1 and a request is pending → rsp_valid=0 immediately, without waiting for a clock edge. After release, the first tie is granted to port 0.
- Random mixed traffic for 10k cycles against a reference model → no lost or duplicated ops, per-port order preserved, stable-while-stalled holds.
